// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and hands them out one at a time
// via start_tx/data_in, paced by tx_busy/tx_done. Define UART_TX_FIFO_OVF_FLAG_EN for a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              start_tx,
  output logic [7:0]        data_in,
  input  logic              tx_busy,
  input  logic              tx_done
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_INC   = ADDR_W'(1);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp, r_rp;
  logic [ADDR_W:0]   r_count;
  logic [7:0]        r_data;
  state_t            r_state, w_next;
  logic              w_pop, w_push, w_full, w_empty;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  // A pop frees a slot on the same edge, so a write into a full FIFO still lands.
  assign w_push   = wr_en && (!w_full || w_pop);

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign data_in  = r_data;
  assign start_tx = (r_state == S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty && !tx_busy) begin
        w_pop  = 1'b1;
        w_next = S_REQ;
      end
      S_REQ:  if (tx_busy) w_next = S_WAIT;
      S_WAIT: if (tx_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_data  <= 8'h00;
    end else begin
      if (w_push) r_wp <= r_wp + LP_INC;
      if (w_pop) begin
        r_rp   <= r_rp + LP_INC;
        r_data <= r_mem[r_rp];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic w_drop;
  logic r_ovf;
  assign w_drop = wr_en && w_full && !w_pop;

  // A drop coinciding with a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end
  assign overflow = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: bytes are queued as written and checked as the
// transmitter model accepts each request.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  localparam bit OVF_EXP = 1'b1;
`else
  localparam bit OVF_EXP = 1'b0;
`endif

  logic clk = 0, rst_n = 0, wr_en = 0, ovf_clr = 0, tx_busy = 0, tx_done = 0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, overflow, start_tx;
  logic [7:0] data_in;
  logic [ADDR_W:0] count;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_exp;
  bit model_en = 0, model_active = 0;
  int model_lat = 4, n_rx = 0;
  logic [ADDR_W:0] peak = '0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .start_tx(start_tx), .data_in(data_in),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (count > peak) peak = count;

  // Transmitter model: accepts a request, stays busy model_lat cycles, then pulses tx_done.
  initial forever begin
    @(negedge clk);
    if (model_en && start_tx && !tx_busy) begin
      model_active = 1;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL model_req: unexpected request data_in=%02h, expected none", data_in);
      end else begin
        m_exp = exp_q.pop_front();
        if (data_in !== m_exp) begin
          n_err++;
          $display("FAIL model_data: data_in=%02h expected %02h", data_in, m_exp);
        end
      end
      n_rx++;
      tx_busy = 1;
      for (int i = 0; i < model_lat; i++) begin
        @(negedge clk);
        n_vec++;
        if (start_tx !== 1'b0) begin
          n_err++;
          $display("FAIL model_no_req_while_busy: start_tx=%b expected 0", start_tx);
        end
      end
      tx_busy = 0;
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
      model_active = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || model_active) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (exp_q.size() != 0 || model_active) begin
      n_err++;
      $display("FAIL drain: %0d bytes outstanding after %0d cycles, expected 0", exp_q.size(), maxc);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({count, empty, full, overflow, start_tx, data_in} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL reset_idle: count=%0d empty=%b full=%b ovf=%b start=%b data=%02h expected 0,1,0,0,0,00",
                 count, empty, full, overflow, start_tx, data_in);
      end
    end
  endtask

  task automatic test_single;
    model_en = 0;
    @(negedge clk); wr_en = 1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 0;
    n_vec++;
    if (count !== 5'd1 || start_tx !== 1'b0) begin
      n_err++; $display("FAIL single_n: count=%0d start=%b expected 1,0", count, start_tx);
    end
    @(negedge clk);
    n_vec++;
    if (start_tx !== 1'b1 || data_in !== 8'hA5 || count !== 5'd0) begin
      n_err++; $display("FAIL single_req: start=%b data=%02h count=%0d expected 1,a5,0", start_tx, data_in, count);
    end
    tx_done = 1; wr_en = 1; wr_data = 8'h5A;
    @(negedge clk); tx_done = 0; wr_en = 0;
    n_vec++;
    if (start_tx !== 1'b1 || data_in !== 8'hA5 || count !== 5'd1) begin
      n_err++; $display("FAIL done_in_req: start=%b data=%02h count=%0d expected 1,a5,1", start_tx, data_in, count);
    end
    tx_busy = 1;
    @(negedge clk); tx_busy = 0;
    n_vec++;
    if (start_tx !== 1'b0 || data_in !== 8'hA5) begin
      n_err++; $display("FAIL req_drop: start=%b data=%02h expected 0,a5", start_tx, data_in);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (start_tx !== 1'b0) begin
        n_err++; $display("FAIL wait_no_req: start=%b expected 0", start_tx);
      end
    end
    tx_done = 1;
    @(negedge clk); tx_done = 0;
    n_vec++;
    if (start_tx !== 1'b0) begin
      n_err++; $display("FAIL idle_reentry: start=%b expected 0", start_tx);
    end
    @(negedge clk);
    n_vec++;
    if (start_tx !== 1'b1 || data_in !== 8'h5A) begin
      n_err++; $display("FAIL second_req: start=%b data=%02h expected 1,5a", start_tx, data_in);
    end
    tx_busy = 1;
    @(negedge clk); tx_busy = 0; tx_done = 1;
    @(negedge clk); tx_done = 0;
    @(negedge clk);
  endtask

  task automatic test_burst;
    int rx0;
    rx0 = n_rx;
    model_lat = 50;
    model_en = 1;
    peak = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); wr_en = 1; wr_data = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(negedge clk); wr_en = 0;
    drain(2000);
    @(negedge clk);
    n_vec++;
    if (peak !== 5'd15 || empty !== 1'b1 || n_rx - rx0 != 16) begin
      n_err++; $display("FAIL burst: peak=%0d empty=%b rx=%0d expected 15,1,16", peak, empty, n_rx - rx0);
    end
    model_en = 0;
  endtask

  task automatic test_overflow;
    model_en = 0;
    tx_busy = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr_en = 1; wr_data = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
    end
    @(negedge clk); wr_data = 8'hEE;
    n_vec++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      n_err++; $display("FAIL full_at_16: full=%b count=%0d ovf=%b expected 1,16,0", full, count, overflow);
    end
    @(negedge clk); wr_en = 0;
    n_vec++;
    if (count !== 5'd16 || overflow !== OVF_EXP) begin
      n_err++; $display("FAIL drop_17th: count=%0d ovf=%b expected 16,%b", count, overflow, OVF_EXP);
    end
    ovf_clr = 1;
    @(negedge clk); ovf_clr = 0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr: ovf=%b expected 0", overflow);
    end
    wr_en = 1; wr_data = 8'hEF; ovf_clr = 1;
    @(negedge clk); wr_en = 0; ovf_clr = 0;
    n_vec++;
    if (overflow !== OVF_EXP || count !== 5'd16) begin
      n_err++; $display("FAIL set_wins: ovf=%b count=%0d expected %b,16", overflow, count, OVF_EXP);
    end
    ovf_clr = 1;
    @(negedge clk); ovf_clr = 0;
  endtask

  task automatic test_wrap;
    model_lat = 3;
    model_en = 1;
    tx_busy = 0;
    wr_en = 1; wr_data = 8'hE0;
    exp_q.push_back(8'hE0);
    @(negedge clk); wr_en = 0;
    n_vec++;
    if (count !== 5'd16 || full !== 1'b1) begin
      n_err++; $display("FAIL push_pop_full: count=%0d full=%b expected 16,1", count, full);
    end
    drain(500);
    @(negedge clk);
    n_vec++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL wrap_end: empty=%b ovf=%b expected 1,0", empty, overflow);
    end
    model_en = 0;
  endtask

  task automatic test_reset_mid;
    model_en = 0;
    tx_busy = 0;
    @(negedge clk); wr_en = 1; wr_data = 8'h77;
    @(negedge clk); wr_en = 1; wr_data = 8'h78;
    @(negedge clk); wr_en = 0;
    n_vec++;
    if (start_tx !== 1'b1 || data_in !== 8'h77) begin
      n_err++; $display("FAIL mid_req: start=%b data=%02h expected 1,77", start_tx, data_in);
    end
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (start_tx !== 1'b0 || count !== 5'd0 || data_in !== 8'h00) begin
      n_err++; $display("FAIL async_reset: start=%b count=%0d data=%02h expected 0,0,00", start_tx, count, data_in);
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (start_tx !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
        n_err++; $display("FAIL post_reset: start=%b count=%0d empty=%b expected 0,0,1", start_tx, count, empty);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_wrap;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
